// File: rtl/mux_rr_sched_if.sv
`default_nettype none
// ============================================================================
// mux_rr_sched_if
// Four producer handshakes plus the single output handshake of mux_rr_sched.
// Revision: 1.0
// ============================================================================
interface mux_rr_sched_if;
  logic       a_valid;
  logic       a_ready;
  logic [3:0] a_data;
  logic       b_valid;
  logic       b_ready;
  logic [5:0] b_data;
  logic       c_valid;
  logic       c_ready;
  logic [6:0] c_data;
  logic       d_valid;
  logic       d_ready;
  logic [7:0] d_data;
  logic       o_valid;
  logic [7:0] o_data;
  logic [1:0] o_src;
  logic       o_ready;

  // Environment side: producers and the downstream consumer
  modport master (
    output a_valid, a_data, b_valid, b_data, c_valid, c_data, d_valid, d_data, o_ready,
    input  a_ready, b_ready, c_ready, d_ready, o_valid, o_data, o_src
  );

  // Scheduler side
  modport slave (
    input  a_valid, a_data, b_valid, b_data, c_valid, c_data, d_valid, d_data, o_ready,
    output a_ready, b_ready, c_ready, d_ready, o_valid, o_data, o_src
  );
endinterface
`default_nettype wire

// File: rtl/mux_rr_sched.sv
`default_nettype none
// ============================================================================
// mux_rr_sched
// Round-robin scheduler of four narrow sources into one registered 8-bit stage.
// Revision: 1.0
// ============================================================================
module mux_rr_sched #(
  parameter int HOLD_MAX = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux_rr_sched_if.slave        bus
);
  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam logic [3:0] C_HOLD_MAX = 4'(HOLD_MAX);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_data,  w_data_nxt;
  logic [1:0] r_src,   w_src_nxt;
  logic [1:0] r_last,  w_last_nxt;
  logic [3:0] r_hold,  w_hold_nxt;

  logic [3:0] w_valid;
  logic [3:0] w_ready;
  logic [1:0] w_win;
  logic [1:0] w_idx;
  logic       w_found;
  logic       w_any;
  logic       w_can_load;
  logic       w_grant;

  // Arbitration: sticky winner while under the hold limit, else rotating scan
  always_comb begin
    w_valid = {bus.d_valid, bus.c_valid, bus.b_valid, bus.a_valid};
    w_any   = |w_valid;
    w_win   = r_last;
    w_idx   = 2'd0;
    w_found = 1'b0;
    if (!(w_valid[r_last] && (r_hold < C_HOLD_MAX))) begin
      for (int i = 1; i <= 4; i++) begin
        w_idx = r_last + 2'(i);
        if (!w_found && w_valid[w_idx]) begin
          w_win   = w_idx;
          w_found = 1'b1;
        end
      end
    end
    w_can_load = (r_state == ST_EMPTY) | bus.o_ready;
    // rst_n gating keeps every ready low while reset is held
    w_grant    = rst_n & w_can_load & w_any;
    w_ready    = w_grant ? (4'b0001 << w_win) : 4'b0000;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_src_nxt   = r_src;
    w_last_nxt  = r_last;
    w_hold_nxt  = r_hold;
    if (w_grant) begin
      w_state_nxt = ST_FULL;
      w_src_nxt   = w_win;
      case (w_win)
        2'd0:    w_data_nxt = {4'b0000, bus.a_data};
        2'd1:    w_data_nxt = {2'b00, bus.b_data};
        2'd2:    w_data_nxt = {1'b0, bus.c_data};
        default: w_data_nxt = bus.d_data;
      endcase
      if (w_win == r_last) begin
        w_hold_nxt = (r_hold == 4'hF) ? r_hold : r_hold + 4'd1;
      end else begin
        w_last_nxt = w_win;
        w_hold_nxt = 4'd1;
      end
    end else if ((r_state == ST_FULL) && bus.o_ready) begin
      w_state_nxt = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_data  <= 8'h00;
      r_src   <= 2'd0;
      r_last  <= 2'd3;
      r_hold  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_src   <= w_src_nxt;
      r_last  <= w_last_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  assign bus.a_ready = w_ready[0];
  assign bus.b_ready = w_ready[1];
  assign bus.c_ready = w_ready[2];
  assign bus.d_ready = w_ready[3];
  assign bus.o_valid = (r_state == ST_FULL);
  assign bus.o_data  = r_data;
  assign bus.o_src   = r_src;
endmodule
`default_nettype wire

// File: tb/tb_mux_rr_sched.sv
`default_nettype none
// ============================================================================
// tb_mux_rr_sched
// Directed bench with scoreboard queues for HOLD_MAX = 1 and HOLD_MAX = 3.
// Revision: 1.0
// ============================================================================
module tb_mux_rr_sched;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic [9:0] q1[$];
  logic [9:0] q3[$];

  mux_rr_sched_if b1();
  mux_rr_sched_if b3();

  mux_rr_sched #(.HOLD_MAX(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  mux_rr_sched #(.HOLD_MAX(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] rdy1();
    return {b1.d_ready, b1.c_ready, b1.b_ready, b1.a_ready};
  endfunction

  function automatic logic [3:0] rdy3();
    return {b3.d_ready, b3.c_ready, b3.b_ready, b3.a_ready};
  endfunction

  // Scoreboards: each word leaving the output stage is checked against the queue head
  always @(negedge clk) begin
    if (rst_n && b1.o_valid && b1.o_ready) begin
      if (q1.size() == 0) chk("q1_extra_word", 32'(q1.size()), 32'd1);
      else chk("q1_word", {22'd0, b1.o_src, b1.o_data}, {22'd0, q1.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (rst_n && b3.o_valid && b3.o_ready) begin
      if (q3.size() == 0) chk("q3_extra_word", 32'(q3.size()), 32'd1);
      else chk("q3_word", {22'd0, b3.o_src, b3.o_data}, {22'd0, q3.pop_front()});
    end
  end

  task automatic set_valid1(input logic [3:0] v);
    b1.a_valid = v[0];
    b1.b_valid = v[1];
    b1.c_valid = v[2];
    b1.d_valid = v[3];
  endtask

  task automatic drive_one(input logic [1:0] src, input logic [7:0] data);
    b1.a_data = data[3:0];
    b1.b_data = data[5:0];
    b1.c_data = data[6:0];
    b1.d_data = data;
    set_valid1(4'b0001 << src);
    @(negedge clk);
    chk("single_ready", 32'(rdy1()), 32'(4'b0001 << src));
    q1.push_back({src, data});
    tick();
    set_valid1(4'b0000);
  endtask

  initial begin
    logic [1:0] src;
    logic [3:0] hold_seq;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    b1.a_valid = 0; b1.b_valid = 0; b1.c_valid = 0; b1.d_valid = 0;
    b1.a_data = 0;  b1.b_data = 0;  b1.c_data = 0;  b1.d_data = 0;
    b1.o_ready = 0;
    b3.a_valid = 0; b3.b_valid = 0; b3.c_valid = 0; b3.d_valid = 0;
    b3.a_data = 0;  b3.b_data = 0;  b3.c_data = 0;  b3.d_data = 0;
    b3.o_ready = 0;

    #12;
    chk("rst_o_valid", 32'(b1.o_valid), 32'd0);
    chk("rst_o_data", 32'(b1.o_data), 32'h00);
    chk("rst_o_src", 32'(b1.o_src), 32'd0);
    chk("rst_ready", 32'(rdy1()), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Zero-extension of the narrow sources
    b1.o_ready = 1'b1;
    drive_one(2'd1, 8'h3F);
    drive_one(2'd2, 8'h7F);
    drive_one(2'd3, 8'hA5);
    tick();

    // Round-robin with all four valid, one word per cycle
    b1.a_data = 4'h1; b1.b_data = 6'h02; b1.c_data = 7'h03; b1.d_data = 8'h04;
    set_valid1(4'b1111);
    for (int k = 0; k < 8; k++) begin
      src = 2'(k);
      @(negedge clk);
      chk("rr_ready", 32'(rdy1()), 32'(4'b0001 << src));
      q1.push_back({src, 8'(k % 4 + 1)});
      tick();
    end

    // Back-pressure: held word 0x04 must stay put and d_ready stay low
    set_valid1(4'b1000);
    b1.d_data  = 8'h5A;
    b1.o_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_d_ready", 32'(b1.d_ready), 32'd0);
      chk("bp_o_valid", 32'(b1.o_valid), 32'd1);
      chk("bp_o_data", 32'(b1.o_data), 32'h04);
      tick();
    end
    b1.o_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(rdy1()), 32'b1000);
    q1.push_back({2'd3, 8'h5A});
    tick();
    set_valid1(4'b0000);
    @(negedge clk);
    chk("bp_no_bubble_valid", 32'(b1.o_valid), 32'd1);
    chk("bp_no_bubble_data", 32'(b1.o_data), 32'h5A);

    // Drain and idle, then confirm the rotation state survived
    tick();
    @(negedge clk);
    chk("drain_o_valid", 32'(b1.o_valid), 32'd0);
    chk("drain_o_data_kept", 32'(b1.o_data), 32'h5A);
    chk("drain_o_src_kept", 32'(b1.o_src), 32'd3);
    tick();
    tick();
    set_valid1(4'b1111);
    @(negedge clk);
    chk("idle_next_grant", 32'(rdy1()), 32'b0001);
    q1.push_back({2'd0, 8'h01});
    tick();
    set_valid1(4'b0000);
    tick();

    // Hold limit of three with a and c competing
    b3.a_data  = 4'h3;
    b3.c_data  = 7'h55;
    b3.a_valid = 1'b1;
    b3.c_valid = 1'b1;
    b3.o_ready = 1'b1;
    hold_seq = 4'b0000;
    for (int k = 0; k < 7; k++) begin
      src = (k >= 3 && k < 6) ? 2'd2 : 2'd0;
      @(negedge clk);
      chk("hold_ready", 32'(rdy3()), 32'(4'b0001 << src));
      q3.push_back({src, (src == 2'd0) ? 8'h03 : 8'h55});
      tick();
    end
    b3.a_valid = 1'b0;
    b3.c_valid = 1'b0;
    tick();
    tick();

    // Asynchronous reset with a word stuck in the output stage
    b1.o_ready = 1'b0;
    b1.a_data  = 4'hF;
    set_valid1(4'b0001);
    @(negedge clk);
    chk("pre_rst_ready", 32'(rdy1()), 32'b0001);
    tick();
    @(negedge clk);
    chk("pre_rst_full", 32'(b1.o_valid), 32'd1);
    chk("pre_rst_stall", 32'(rdy1()), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_o_valid", 32'(b1.o_valid), 32'd0);
    chk("mid_rst_o_data", 32'(b1.o_data), 32'h00);
    chk("mid_rst_o_src", 32'(b1.o_src), 32'd0);
    chk("mid_rst_ready", 32'(rdy1()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    b1.o_ready = 1'b1;
    #1;
    chk("post_rst_ready", 32'(rdy1()), 32'b0001);
    q1.push_back({2'd0, 8'h0F});
    tick();
    set_valid1(4'b0000);
    @(negedge clk);
    chk("post_rst_o_data", 32'(b1.o_data), 32'h0F);
    chk("post_rst_o_src", 32'(b1.o_src), 32'd0);
    tick();
    tick();

    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("q3_drained", 32'(q3.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mux_rr_sched.md
# mux_rr_sched

Round-robin scheduler that shares the 8-bit zero-extending 4:1 select datapath between four requesters of widths 4, 6, 7 and 8 bits. Each requester has its own valid/ready handshake. The block arbitrates among them and drives the 2-bit select internally. It registers the zero-extended winner with its source ID into a single-entry output stage that has its own valid/ready handshake. The block sits between the four producers and a single downstream 8-bit consumer.

## Interface
Parameters:
- HOLD_MAX, default 1: maximum consecutive grants to one source before priority rotates. Legal range is 1..15.

Ports:
- clk, input, 1: the single clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- a_valid / a_ready, in / out, 1 / 1: handshake for source 0; a_data, input, 4.
- b_valid / b_ready, in / out, 1 / 1: handshake for source 1; b_data, input, 6.
- c_valid / c_ready, in / out, 1 / 1: handshake for source 2; c_data, input, 7.
- d_valid / d_ready, in / out, 1 / 1: handshake for source 3; d_data, input, 8.
- o_valid, output, 1: the output register holds a word.
- o_data, output, 8: the zero-extended winner data.
- o_src, output, 2: ID of the source that produced o_data (0 = a … 3 = d).
- o_ready, input, 1: the consumer accepts the word.

## Operation
- **Transfer rule:** a transfer occurs on any edge where valid and ready are both 1, on inputs and on the output.
- **State register:** o_valid doubles as the state. EMPTY means o_valid = 0; FULL means o_valid = 1.
- **can_load:** can_load = !o_valid | o_ready. The output stage accepts a new word when empty, or when its word leaves in the same cycle.
- **Grant selection (combinational):**
  - If source `last` has its valid set and hold_cnt < HOLD_MAX, `last` wins.
  - Otherwise the winner is the first valid source scanning last+1, last+2, last+3, last (mod 4).
- **Ready outputs:** x_ready = can_load & (winner == x). At most one ready is high per cycle. A ready is never high for a source whose valid is low.
- **On an input transfer, winner w:**
  - o_data <= zero-extended data of w: {4'b0,a}, {2'b0,b}, {1'b0,c} or d.
  - o_src <= w; o_valid <= 1.
  - If w == last, hold_cnt <= hold_cnt + 1, saturating at 15. Otherwise last <= w and hold_cnt <= 1.
- **Output transfer with no input transfer:** o_valid <= 0. o_data and o_src keep their values.
- **FULL with o_ready = 0:** all of o_valid, o_data, o_src, last and hold_cnt are held. All x_ready = 0.
- **No valid sources:** no grant is made, and last and hold_cnt are unchanged.
- **hold_cnt reset on idle:** hold_cnt is not cleared when `last` drops valid. It resets only when a different source wins.
- **Reset values:**
  - o_valid = 0, o_data = 8'h00, o_src = 2'd0.
  - last = 2'd3, so source a has first priority; hold_cnt = 0.
  - All x_ready = 0 while rst_n = 0.
- **Reset mid-operation:** asserting rst_n clears everything immediately, independent of clk. A word held in the output stage is discarded. No partial transfer is reported.

## Timing
- **Latency:** input transfer at edge N gives o_valid = 1 with the data after edge N.
- **Throughput:** one word per cycle while o_ready = 1 and any source is valid.
- **Back-pressure:** ready is deasserted in the same cycle that o_valid = 1 and o_ready = 0. The datapath has no combinational path from input data to o_data.
- **Combinational ready paths:** x_ready depends combinationally on the x_valid signals, o_valid, o_ready, last and hold_cnt.
- **Source obligations:** sources must hold valid and data stable until their transfer occurs.
- **Sequential output changes:** o_valid, o_data and o_src change only on the clk rising edge or on reset assertion.

## Test plan
- **Reset:** assert rst_n = 0 mid-stream while the output is FULL. Required: o_valid = 0, o_data = 8'h00, o_src = 0 and all ready = 0 immediately. After release, with a_valid = 1, a_data = 4'hF and o_ready = 1, the next cycle shows o_data = 8'h0F, o_src = 0.
- **Zero-extension:** present single requests with o_ready = 1.
  - b_data = 6'h3F → o_data = 8'h3F, o_src = 1.
  - c_data = 7'h7F → 8'h7F, o_src = 2.
  - d_data = 8'hA5 → 8'hA5, o_src = 3.
- **Round-robin:** HOLD_MAX = 1, all four valid continuously, o_ready = 1. Required: o_src sequence 0, 1, 2, 3, 0, 1… with one word per cycle. Each ready is high exactly on its grant cycle.
- **Hold:** HOLD_MAX = 3, sources a and c both valid. Required: o_src = 0, 0, 0, 2, 2, 2, 0….
- **Back-pressure:** o_valid = 1, o_ready = 0 for 5 cycles with d_valid = 1. Required: d_ready = 0 and o_data stable throughout. When o_ready rises, d_ready = 1 in the same cycle, and the new word appears on the next edge with no bubble.
- **Drain and idle:** a single word is accepted, then no sources are valid and o_ready = 1. Required: o_valid falls the cycle after the output transfer. last and hold_cnt are unchanged, verified by the next grant order.
